onehot_scan_decoder: RTL and testbench

ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

---
 rtl/onehot_scan_decoder.sv | 85 ++++++++
 tb/tb_onehot_scan_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_scan_decoder.sv
// rtl/onehot_scan_decoder.sv - one-hot index decoder with direct load and dwell-timed auto-scan
// Defining DEC_BIDIR_EN adds a dir input that lets the scan step downward.
module onehot_scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [DWELL_W-1:0]    dwell,
`ifdef DEC_BIDIR_EN
  input  logic                  dir,
`endif
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               en_r_q, en_r_d;
  logic               wrap_q, wrap_d;
  logic               step_rev;

`ifdef DEC_BIDIR_EN
  assign step_rev = dir;
`else
  assign step_rev = 1'b0;
`endif

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    en_r_d = en;
    wrap_d = 1'b0;
    if (load) begin
      idx_d = sel_in;
      cnt_d = '0;
    end else if (!mode) begin
      cnt_d = '0;
    end else if (en) begin
      // >= so that lowering dwell beneath a running count expires it at once
      if (cnt_q >= dwell) begin
        cnt_d = '0;
        if (step_rev) begin
          idx_d  = idx_q - 1'b1;
          wrap_d = (idx_q == '0);
        end else begin
          idx_d  = idx_q + 1'b1;
          wrap_d = (idx_q == IDX_MAX);
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      en_r_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      en_r_q <= en_r_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    out = '0;
    if (en_r_q) out[idx_q] = 1'b1;
  end

  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb/tb_onehot_scan_decoder.sv - scoreboard bench for onehot_scan_decoder
// Build with DEC_BIDIR_EN defined to also exercise reverse scanning.
module tb_onehot_scan_decoder;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] out;
    logic       wrap;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, mode, load;
  logic [2:0] sel_in;
  logic [7:0] dwell;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;
`ifdef DEC_BIDIR_EN
  logic       dir;
`endif

  exp_t sb[$];
  event chk_ev;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .mode   (mode),
    .load   (load),
    .sel_in (sel_in),
    .dwell  (dwell),
`ifdef DEC_BIDIR_EN
    .dir    (dir),
`endif
    .out    (out),
    .idx    (idx),
    .wrap   (wrap)
  );

  always begin
    exp_t e;
    @(negedge clk or chk_ev);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (idx === e.idx) passed++;
      else $display("FAIL %s idx got %0d want %0d", e.nm, idx, e.idx);
      total++;
      if (out === e.out) passed++;
      else $display("FAIL %s out got %b want %b", e.nm, out, e.out);
      total++;
      if (wrap === e.wrap) passed++;
      else $display("FAIL %s wrap got %b want %b", e.nm, wrap, e.wrap);
    end
  end

  task automatic push(input logic [2:0] ei, input logic [7:0] eo, input logic ew, input string nm);
    exp_t e;
    e.idx = ei; e.out = eo; e.wrap = ew; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic e, input logic m, input logic l, input logic [2:0] s,
                      input logic [7:0] d, input logic [2:0] ei, input logic [7:0] eo,
                      input logic ew, input string nm);
    en = e; mode = m; load = l; sel_in = s; dwell = d;
    @(posedge clk);
    #1;
    push(ei, eo, ew, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel_in = '0; dwell = '0;
`ifdef DEC_BIDIR_EN
    dir = 1'b0;
`endif
    @(posedge clk); #1;
    push(3'd0, 8'h00, 1'b0, "reset");
    @(negedge clk);
    reset_n = 1'b1;

    // direct load and hold
    step(1, 0, 1, 3'd5, 8'd0, 3'd5, 8'h20, 0, "load5");
    step(1, 0, 0, 3'd0, 8'd0, 3'd5, 8'h20, 0, "direct_hold");

    // dwell=2 scan from 6 through a wrap
    step(1, 1, 1, 3'd6, 8'd2, 3'd6, 8'h40, 0, "load6");
    step(1, 1, 0, 3'd0, 8'd2, 3'd6, 8'h40, 0, "scan_c1");
    step(1, 1, 0, 3'd0, 8'd2, 3'd6, 8'h40, 0, "scan_c2");
    step(1, 1, 0, 3'd0, 8'd2, 3'd7, 8'h80, 0, "scan_adv7");
    step(1, 1, 0, 3'd0, 8'd2, 3'd7, 8'h80, 0, "scan_c1b");
    step(1, 1, 0, 3'd0, 8'd2, 3'd7, 8'h80, 0, "scan_c2b");
    step(1, 1, 0, 3'd0, 8'd2, 3'd0, 8'h01, 1, "scan_wrap");
    step(1, 1, 0, 3'd0, 8'd2, 3'd0, 8'h01, 0, "wrap_clear");

    // dwell=3 with an enable gap at cnt=2
    step(1, 1, 1, 3'd3, 8'd3, 3'd3, 8'h08, 0, "load3");
    step(1, 1, 0, 3'd0, 8'd3, 3'd3, 8'h08, 0, "gap_c1");
    step(1, 1, 0, 3'd0, 8'd3, 3'd3, 8'h08, 0, "gap_c2");
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 3'd0, 8'd3, 3'd3, 8'h00, 0, "gap_off");
    step(1, 1, 0, 3'd0, 8'd3, 3'd3, 8'h08, 0, "gap_resume");
    step(1, 1, 0, 3'd0, 8'd3, 3'd4, 8'h10, 0, "gap_adv");

    // dwell lowered beneath the running count
    step(1, 1, 0, 3'd0, 8'd3, 3'd4, 8'h10, 0, "low_c1");
    step(1, 1, 0, 3'd0, 8'd3, 3'd4, 8'h10, 0, "low_c2");
    step(1, 1, 0, 3'd0, 8'd1, 3'd5, 8'h20, 0, "low_expire");

    // load beats an expiring advance
    step(1, 1, 0, 3'd0, 8'd1, 3'd5, 8'h20, 0, "pri_c1");
    step(1, 1, 1, 3'd2, 8'd1, 3'd2, 8'h04, 0, "pri_load2");
    step(1, 1, 0, 3'd0, 8'd1, 3'd2, 8'h04, 0, "pri_cnt_clr");
    step(1, 1, 0, 3'd0, 8'd1, 3'd3, 8'h08, 0, "pri_adv");

    // mode toggle clears the dwell count
    step(1, 1, 0, 3'd0, 8'd1, 3'd3, 8'h08, 0, "mode_c1");
    step(1, 0, 0, 3'd0, 8'd1, 3'd3, 8'h08, 0, "mode_direct");
    step(1, 1, 0, 3'd0, 8'd1, 3'd3, 8'h08, 0, "mode_restart");
    step(1, 1, 0, 3'd0, 8'd1, 3'd4, 8'h10, 0, "mode_adv");

    // dwell=0 advances every cycle
    step(1, 1, 0, 3'd0, 8'd0, 3'd5, 8'h20, 0, "d0_5");
    step(1, 1, 0, 3'd0, 8'd0, 3'd6, 8'h40, 0, "d0_6");
    step(1, 1, 0, 3'd0, 8'd0, 3'd7, 8'h80, 0, "d0_7");
    step(1, 1, 0, 3'd0, 8'd0, 3'd0, 8'h01, 1, "d0_wrap");
    step(1, 1, 0, 3'd0, 8'd0, 3'd1, 8'h02, 0, "d0_1");

    // a load of 0 from 7 is not a wrap
    step(1, 0, 1, 3'd7, 8'd0, 3'd7, 8'h80, 0, "load7");
    step(1, 0, 1, 3'd0, 8'd0, 3'd0, 8'h01, 0, "load0_nowrap");

    // asynchronous reset mid-dwell at idx=4, cnt=1
    step(1, 1, 1, 3'd4, 8'd3, 3'd4, 8'h10, 0, "pre_rst_load");
    step(1, 1, 0, 3'd0, 8'd3, 3'd4, 8'h10, 0, "pre_rst_c1");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    push(3'd0, 8'h00, 1'b0, "async_rst");
    ->chk_ev;
    en = 1'b1; mode = 1'b1; load = 1'b0; dwell = 8'd1;
    @(posedge clk); #1;
    push(3'd0, 8'h00, 1'b0, "rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 0, 3'd0, 8'd1, 3'd0, 8'h01, 0, "post_rst_c1");
    step(1, 1, 0, 3'd0, 8'd1, 3'd1, 8'h02, 0, "post_rst_adv");

`ifdef DEC_BIDIR_EN
    step(1, 1, 1, 3'd1, 8'd0, 3'd1, 8'h02, 0, "bi_load1");
    dir = 1'b1;
    step(1, 1, 0, 3'd0, 8'd0, 3'd0, 8'h01, 0, "bi_0");
    step(1, 1, 0, 3'd0, 8'd0, 3'd7, 8'h80, 1, "bi_wrap7");
    step(1, 1, 0, 3'd0, 8'd0, 3'd6, 8'h40, 0, "bi_6");
    dir = 1'b0;
`endif

    repeat (4) @(negedge clk);
    #1;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain pending got %0d want 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
